controle_mult_div: RTL and testbench

Iterative multiply/divide sequencer for the MIPS datapath. It takes the ALU control codes for mult (000010) and div (000011) and runs a WIDTH-cycle shift-add multiply or restoring divide. It holds Busy so the pipeline stalls, then returns the 2·WIDTH-bit result as Hi/Lo. It sits beside the single-cycle ALU and is launched by the control unit whenever ALU_Ctrl selects mult or div.

---
 rtl/controle_mult_div.sv | 185 ++++++++++++++++++
 tb/tb_controle_mult_div.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_mult_div.sv
// Iterative shift-add multiply / restoring divide sequencer with Busy/Done handshake.
// Optional MULDIV_SIGNED_EN: two's-complement operands, magnitude core with sign fix-up at FIM entry.
module controle_mult_div #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [5:0]       ALU_Ctrl,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             Div_Zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [5:0] OP_MULT = 6'b000010;
    localparam logic [5:0] OP_DIV  = 6'b000011;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIM  = 2'd2;

    logic [1:0]       state, state_next;
    logic [CW-1:0]    cnt;
    logic             is_div;
    logic             b_zero;
    logic [WIDTH-1:0] a_raw;
    logic [WIDTH-1:0] m_op;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] op_a, op_b;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] diff;
    logic             accept;
    logic             last;

    assign accept = Start && ((ALU_Ctrl == OP_MULT) || (ALU_Ctrl == OP_DIV));
    assign last   = (state == S_CALC) && (cnt == '0);

`ifdef MULDIV_SIGNED_EN
    logic neg_q, neg_r;
    logic [2*WIDTH-1:0] prod;

    assign op_a = A[WIDTH-1] ? -A : A;
    assign op_b = B[WIDTH-1] ? -B : B;

    // Sign fix-up on the final iteration's values; zero divisor reports raw A.
    always_comb begin
        prod   = {step_hi, step_lo};
        res_hi = step_hi;
        res_lo = step_lo;
        if (!is_div) begin
            if (neg_q) begin
                prod = -prod;
            end
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else if (b_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end else begin
            res_hi = neg_r ? -step_hi : step_hi;
            res_lo = neg_q ? -step_lo : step_lo;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if ((state == S_IDLE) && accept) begin
            neg_q <= A[WIDTH-1] ^ B[WIDTH-1];
            neg_r <= A[WIDTH-1];
        end
    end
`else
    assign op_a = A;
    assign op_b = B;

    always_comb begin
        res_hi = step_hi;
        res_lo = step_lo;
        if (is_div && b_zero) begin
            res_hi = a_raw;
            res_lo = '1;
        end
    end
`endif

    // One iteration: mult shifts {acc_hi,acc_lo} right, div shifts left.
    always_comb begin
        sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_op} : '0);
        rem_sh = {acc_hi, acc_lo[WIDTH-1]};
        diff   = WIDTH'(rem_sh - {1'b0, m_op});
        if (is_div) begin
            if (rem_sh >= {1'b0, m_op}) begin
                step_hi = diff;
                step_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                step_hi = rem_sh[WIDTH-1:0];
                step_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            step_hi = sum[WIDTH:1];
            step_lo = {sum[0], acc_lo[WIDTH-1:1]};
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_CALC;
            S_CALC:  if (cnt == '0) state_next = S_FIM;
            S_FIM:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture and iteration datapath.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt    <= '0;
            is_div <= 1'b0;
            b_zero <= 1'b0;
            a_raw  <= '0;
            m_op   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
        end else if ((state == S_IDLE) && accept) begin
            cnt    <= CW'(WIDTH - 1);
            is_div <= ALU_Ctrl[0];
            b_zero <= (B == '0);
            a_raw  <= A;
            acc_hi <= '0;
            if (ALU_Ctrl[0]) begin
                acc_lo <= op_a;
                m_op   <= op_b;
            end else begin
                acc_lo <= op_b;
                m_op   <= op_a;
            end
        end else if (state == S_CALC) begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            if (cnt != '0) begin
                cnt <= cnt - CW'(1);
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
            Div_Zero <= 1'b0;
        end else begin
            Busy <= (state_next != S_IDLE);
            Done <= (state_next == S_FIM);
            if (last) begin
                Hi       <= res_hi;
                Lo       <= res_lo;
                Div_Zero <= is_div && b_zero;
            end
        end
    end

endmodule

// File: tb/tb_controle_mult_div.sv
// Self-checking bench: cycle-level result/latency model plus directed literal checks.
module tb_controle_mult_div;

    localparam int unsigned W = 32;
    localparam logic [5:0] OP_MULT = 6'b000010;
    localparam logic [5:0] OP_DIV  = 6'b000011;
    localparam logic [5:0] OP_AND  = 6'b000101;

    logic          Clock = 1'b0;
    logic          Reset_n;
    logic          Start;
    logic [5:0]    ALU_Ctrl;
    logic [W-1:0]  A, B;
    logic          Busy, Done, Div_Zero;
    logic [W-1:0]  Hi, Lo;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    controle_mult_div #(.WIDTH(W)) dut (
        .Clock(Clock), .Reset_n(Reset_n), .Start(Start), .ALU_Ctrl(ALU_Ctrl),
        .A(A), .B(B), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo), .Div_Zero(Div_Zero)
    );

    always #5 Clock = ~Clock;

    // Reference result: {hi, lo, div_zero}.
    function automatic logic [64:0] ref_op(input logic is_div, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        logic [31:0] q, r;
`ifdef MULDIV_SIGNED_EN
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
`endif
        if (!is_div) begin
`ifdef MULDIV_SIGNED_EN
            p = 64'(sa * sb);
`else
            p = {32'd0, a} * {32'd0, b};
`endif
            return {p, 1'b0};
        end
        if (b == 32'd0) return {a, 32'hFFFF_FFFF, 1'b1};
`ifdef MULDIV_SIGNED_EN
        q = 32'(sa / sb);
        r = 32'(sa % sb);
`else
        q = a / b;
        r = a % b;
`endif
        return {r, q, 1'b0};
    endfunction

    // Model: edges remaining until idle; result published when one edge remains.
    int          m_cnt = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_dz = 1'b0, p_dz = 1'b0;

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            m_cnt <= 0;
            m_hi  <= '0;
            m_lo  <= '0;
            m_dz  <= 1'b0;
        end else if (m_cnt == 0) begin
            if (Start && (ALU_Ctrl == OP_MULT || ALU_Ctrl == OP_DIV)) begin
                m_cnt <= W + 1;
                {p_hi, p_lo, p_dz} <= ref_op(ALU_Ctrl == OP_DIV, A, B);
            end
        end else begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
                m_dz <= p_dz;
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge Clock) begin
        if (check_en) begin
            chk("busy", 64'(Busy), 64'(m_cnt != 0));
            chk("done", 64'(Done), 64'(m_cnt == 1));
            chk("hi", 64'(Hi), 64'(m_hi));
            chk("lo", 64'(Lo), 64'(m_lo));
            chk("div_zero", 64'(Div_Zero), 64'(m_dz));
        end
    end

    task automatic launch(input logic [5:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        Start = 1'b1;
        ALU_Ctrl = ctrl;
        A = a;
        B = b;
        @(posedge Clock);
        #2;
        Start = 1'b0;
        A = $urandom;
        B = $urandom;
        ALU_Ctrl = 6'($urandom);
    endtask

    // Returns number of negedges after the launch edge until Done; leaves time at posedge+2.
    task automatic wait_done(output int n);
        bit ok = 1'b0;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge Clock);
            if (Done) begin
                ok = 1'b1;
                n = i;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL done_timeout: no Done within 60 cycles at %0t", $time);
        end
    endtask

    task automatic realign();
        @(posedge Clock);
        #2;
    endtask

    task automatic run_lit(input string nm, input logic [5:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input logic edz);
        int n;
        launch(ctrl, a, b);
        wait_done(n);
        chk({nm, "_latency"}, 64'(n), 64'(W));
        chk({nm, "_hi"}, 64'(Hi), 64'(ehi));
        chk({nm, "_lo"}, 64'(Lo), 64'(elo));
        chk({nm, "_dz"}, 64'(Div_Zero), 64'(edz));
        realign();
    endtask

    initial begin
        int n;
        Reset_n = 1'b0;
        Start = 1'b0;
        ALU_Ctrl = 6'd0;
        A = '0;
        B = '0;
        repeat (2) @(posedge Clock);
        #2;
        check_en = 1'b1;
        chk("reset_busy", 64'(Busy), 64'd0);
        chk("reset_lo", 64'(Lo), 64'd0);
        Reset_n = 1'b1;
        realign();

        run_lit("mul7x6", OP_MULT, 32'd7, 32'd6, 32'd0, 32'd42, 1'b0);

        launch(OP_AND, 32'd9, 32'd9);
        @(negedge Clock);
        chk("and_busy", 64'(Busy), 64'd0);
        chk("and_lo", 64'(Lo), 64'd42);
        realign();

`ifdef MULDIV_SIGNED_EN
        run_lit("mul_m1sq", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h1, 1'b0);
        run_lit("sdiv_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_lit("smul_m3_4", OP_MULT, 32'hFFFF_FFFD, 32'd4, 32'hFFFF_FFFF, 32'hFFFF_FFF4, 1'b0);
        run_lit("sdiv_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
`else
        run_lit("mul_max", OP_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, 1'b0);
`endif
        run_lit("div100_7", OP_DIV, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_lit("div0", OP_DIV, 32'h1234_5678, 32'd0, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);

        // Start mid-CALC with different operands must be ignored.
        launch(OP_DIV, 32'd100, 32'd7);
        repeat (5) @(posedge Clock);
        #2;
        Start = 1'b1; ALU_Ctrl = OP_MULT; A = 32'd3; B = 32'd3;
        realign();
        Start = 1'b0;
        wait_done(n);
        chk("midcalc_lo", 64'(Lo), 64'd14);
        chk("midcalc_hi", 64'(Hi), 64'd2);
        realign();

        // Asynchronous reset ten cycles into CALC.
        launch(OP_MULT, 32'h1234, 32'h5678);
        repeat (10) @(posedge Clock);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst_busy", 64'(Busy), 64'd0);
        chk("arst_done", 64'(Done), 64'd0);
        chk("arst_hi", 64'(Hi), 64'd0);
        chk("arst_lo", 64'(Lo), 64'd0);
        chk("arst_dz", 64'(Div_Zero), 64'd0);
        realign();
        Reset_n = 1'b1;
        realign();
        run_lit("mul3x5", OP_MULT, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);

        // Randomized operations, some with noise pulses during CALC.
        for (int k = 0; k < 40; k++) begin
            int sel;
            logic [31:0] ra, rb;
            sel = int'($urandom_range(0, 4));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 0) rb = -rb;
            case (sel)
                0, 1: launch(OP_MULT, ra, rb);
                2:    launch(OP_DIV, ra, rb);
                3:    launch(OP_DIV, ra, 32'd0);
                default: launch(6'(($urandom_range(4, 63))), ra, rb);
            endcase
            if (sel < 4) begin
                if ($urandom_range(0, 1) == 1) begin
                    repeat ($urandom_range(1, 20)) @(posedge Clock);
                    #2;
                    Start = 1'b1;
                    ALU_Ctrl = ($urandom_range(0, 1) == 1) ? OP_MULT : OP_DIV;
                    realign();
                    Start = 1'b0;
                end
                wait_done(n);
                realign();
            end
        end

        repeat (2) realign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
